// File: rtl/loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
// Consumed by imem_program_loader and, when LOADER_CHECKSUM_EN is defined, loader_checksum.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HI,
        ST_LO,
        ST_WR,
        ST_FIN,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    localparam int BYTES_PER_WORD = 2;

    // The header byte carries N-1, so a single byte can describe 1..256 words.
    function automatic logic [8:0] hdrToCount(input logic [7:0] hdr);
        return {1'b0, hdr} + 9'd1;
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running 8-bit XOR over the accepted payload bytes of one load.
// Only instantiated when LOADER_CHECKSUM_EN is defined.
module loader_checksum (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q;

    // Clear takes priority so a new load never inherits the previous sum.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sum_q <= 8'h00;
        end else if (clear_i) begin
            sum_q <= 8'h00;
        end else if (enable_i) begin
            sum_q <= sum_q ^ data_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/imem_program_loader.sv
// Byte-stream loader that fills instruction memory and holds the CPU until the load completes.
// Optional trailing-checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [ADDR_W:0]    words_loaded
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int WORD_W = 8 * BYTES_PER_WORD;

    loader_state_e     state_q;
    logic [CNT_W-1:0]  numWords_q;
    logic [CNT_W-1:0]  wordsLoaded_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        hiByte_q;
    logic [WORD_W-1:0] wdata_q;
    logic              we_q;
    logic              hold_q;
    logic              done_q;

    logic              accept;
    logic              startOk;
    logic [CNT_W-1:0]  wordsLoaded_d;
    logic              lastWord;

    assign accept        = in_valid & in_ready;
    assign startOk       = start & (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign wordsLoaded_d = wordsLoaded_q + CNT_W'(1);
    assign lastWord      = (wordsLoaded_d == numWords_q);

`ifdef LOADER_CHECKSUM_EN
    logic       err_q;
    logic [7:0] xorSum;
    logic       sumEnable;

    // FIN also accepts a byte: the trailing checksum.
    assign in_ready  = state_q inside {ST_HDR, ST_HI, ST_LO, ST_FIN};
    assign sumEnable = accept & (state_q inside {ST_HI, ST_LO});
    assign load_err  = err_q;

    loader_checksum u_checksum (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (startOk),
        .enable_i (sumEnable),
        .data_i   (in_data),
        .sum_o    (xorSum)
    );
`else
    assign in_ready = state_q inside {ST_HDR, ST_HI, ST_LO};
    assign load_err = 1'b0;
`endif

    // Single FSM register block; every output is a register or a decode of state_q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            numWords_q    <= '0;
            wordsLoaded_q <= '0;
            addr_q        <= '0;
            hiByte_q      <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            hold_q        <= 1'b1;
            done_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_q         <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (startOk) begin
                        state_q       <= ST_HDR;
                        hold_q        <= 1'b1;
                        done_q        <= 1'b0;
                        wordsLoaded_q <= '0;
                        addr_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
                        err_q         <= 1'b0;
`endif
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        numWords_q <= CNT_W'(hdrToCount(in_data));
                        state_q    <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (accept) begin
                        hiByte_q <= in_data;
                        state_q  <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (accept) begin
                        wdata_q <= {hiByte_q, in_data};
                        we_q    <= 1'b1;
                        state_q <= ST_WR;
                    end
                end
                // The address stays on the last word written, so a full-depth load never wraps.
                ST_WR: begin
                    wordsLoaded_q <= wordsLoaded_d;
                    if (lastWord) begin
                        state_q <= ST_FIN;
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= ST_HI;
                    end
                end
                ST_FIN: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept) begin
                        if (in_data == xorSum) begin
                            state_q <= ST_DONE;
                            hold_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
`else
                    state_q <= ST_DONE;
                    hold_q  <= 1'b0;
                    done_q  <= 1'b1;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign words_loaded = wordsLoaded_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a vector table plus multi-cycle sequences.
// Build with LOADER_CHECKSUM_EN defined to also exercise the trailing checksum.
module tb_imem_program_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [8:0]  words_loaded;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        eReady;
        logic        eWe;
        logic [7:0]  eAddr;
        logic [15:0] eWdata;
        logic        eHold;
        logic        eDone;
        logic        eErr;
        logic [8:0]  eWords;
    } vec_t;

    vec_t vecs[$];
    logic [7:0]  payload[512];
    logic [7:0]  wrAddr[$];
    logic [15:0] wrData[$];
    logic        wrRdy[$];
    logic        monEn = 1'b0;

    imem_program_loader #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor samples on the falling edge, mid-way through each WR cycle.
    always @(negedge clk) begin
        if (monEn && imem_we) begin
            wrAddr.push_back(imem_addr);
            wrData.push_back(imem_wdata);
            wrRdy.push_back(in_ready);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(logic st, logic v, logic [7:0] d, logic rdy, logic we,
                                   logic [7:0] a, logic [15:0] wd, logic hold, logic done,
                                   logic err, logic [8:0] wl);
        vec_t r;
        r.start = st; r.valid = v; r.data = d;
        r.eReady = rdy; r.eWe = we; r.eAddr = a; r.eWdata = wd;
        r.eHold = hold; r.eDone = done; r.eErr = err; r.eWords = wl;
        return r;
    endfunction

    task automatic applyStimulus(input logic st, input logic v, input logic [7:0] d);
        @(negedge clk);
        start    = st;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input vec_t e, input string name);
        logic ok;
        ok = (in_ready === e.eReady) && (imem_we === e.eWe) && (cpu_hold === e.eHold) &&
             (load_done === e.eDone) && (load_err === e.eErr) && (words_loaded === e.eWords);
        if (e.eWe)
            ok = ok && (imem_addr === e.eAddr) && (imem_wdata === e.eWdata);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s: got rdy=%0b we=%0b addr=%h wd=%h hold=%0b done=%0b err=%0b words=%0d; want rdy=%0b we=%0b addr=%h wd=%h hold=%0b done=%0b err=%0b words=%0d",
                     name, in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done,
                     load_err, words_loaded, e.eReady, e.eWe, e.eAddr, e.eWdata, e.eHold,
                     e.eDone, e.eErr, e.eWords);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 16; n++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL sendByte timeout: byte %h not accepted, want accepted", b);
        end
    endtask

    task automatic waitFinish();
        for (int n = 0; n < 10; n++) begin
            if (load_done || load_err) break;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t idleVec;
        logic [7:0] xorAcc;
        int nWr;

        idleVec = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd0);

        // Frame 01,12,34,AB,CD then a start-with-valid in DONE and a start ignored in HI.
        vecs.push_back(mkVec(1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd0));
        vecs.push_back(mkVec(0, 1, 8'h01, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd0));
        vecs.push_back(mkVec(0, 1, 8'h12, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd0));
        vecs.push_back(mkVec(0, 1, 8'h34, 0, 1, 8'h00, 16'h1234, 1, 0, 0, 9'd0));
        vecs.push_back(mkVec(0, 1, 8'hAB, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd1));
        vecs.push_back(mkVec(0, 1, 8'hAB, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd1));
        vecs.push_back(mkVec(0, 1, 8'hCD, 0, 1, 8'h01, 16'hABCD, 1, 0, 0, 9'd1));
        vecs.push_back(mkVec(0, 0, 8'h00, CK, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd2));
        vecs.push_back(mkVec(0, CK, 8'h40, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 9'd2));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 9'd2));
        vecs.push_back(mkVec(1, 1, 8'h55, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd0));
        vecs.push_back(mkVec(0, 1, 8'h00, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd0));
        vecs.push_back(mkVec(1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd0));
        vecs.push_back(mkVec(0, 1, 8'h77, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd0));
        vecs.push_back(mkVec(0, 1, 8'h88, 0, 1, 8'h00, 16'h7788, 1, 0, 0, 9'd0));
        vecs.push_back(mkVec(0, 0, 8'h00, CK, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd1));
        vecs.push_back(mkVec(0, CK, 8'hFF, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 9'd1));

        // Reset held low for two cycles.
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput(idleVec, "reset state");
        checkValue("reset imem_addr", int'(imem_addr), 0);
        checkValue("reset imem_wdata", int'(imem_wdata), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].valid, vecs[i].data);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        // Full-depth load of 256 words with random valid gaps.
        xorAcc = 8'h00;
        for (int i = 0; i < 512; i++) begin
            payload[i] = 8'($urandom_range(0, 255));
            xorAcc ^= payload[i];
        end
        wrAddr.delete(); wrData.delete(); wrRdy.delete();
        monEn = 1'b1;
        applyStimulus(1, 0, 8'h00);
        sendByte(8'hFF);
        for (int i = 0; i < 512; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sendByte(payload[i]);
        end
        if (CK) sendByte(xorAcc);
        waitFinish();
        checkValue("full load_done", int'(load_done), 1);
        checkValue("full cpu_hold", int'(cpu_hold), 0);
        checkValue("full words_loaded", int'(words_loaded), 256);
        checkValue("full write count", wrAddr.size(), 256);
        nWr = (wrAddr.size() < 256) ? wrAddr.size() : 256;
        for (int i = 0; i < nWr; i++) begin
            checkValue($sformatf("full addr%0d", i), int'(wrAddr[i]), i);
            checkValue($sformatf("full data%0d", i), int'(wrData[i]),
                       int'({payload[2*i], payload[2*i+1]}));
            checkValue($sformatf("full bubble%0d", i), int'(wrRdy[i]), 0);
        end

        // Reset arriving after the hi byte of word 3 discards the partial word.
        wrAddr.delete(); wrData.delete(); wrRdy.delete();
        applyStimulus(1, 0, 8'h00);
        sendByte(8'h03);
        for (int i = 0; i < 6; i++) sendByte(8'(8'h21 + i));
        sendByte(8'hEE);
        checkValue("abort words before reset", int'(words_loaded), 3);
        checkValue("abort writes before reset", wrAddr.size(), 3);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput(idleVec, "abort reset state");
        checkValue("abort imem_addr", int'(imem_addr), 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 1, 8'h5A);
        applyStimulus(0, 1, 8'h5A);
        checkOutput(idleVec, "abort stays idle");
        checkValue("abort no extra write", wrAddr.size(), 3);

`ifdef LOADER_CHECKSUM_EN
        applyStimulus(1, 0, 8'h00);
        sendByte(8'h00); sendByte(8'h12); sendByte(8'h34); sendByte(8'h26);
        waitFinish();
        checkOutput(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 9'd1), "csum match");
        applyStimulus(1, 0, 8'h00);
        sendByte(8'h00); sendByte(8'h12); sendByte(8'h34); sendByte(8'h27);
        waitFinish();
        checkOutput(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 9'd1), "csum mismatch");
        applyStimulus(1, 0, 8'h00);
        checkOutput(mkVec(0, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 9'd0), "csum err cleared");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
